// File: rtl/ppu_pkg.sv
// ppu_pkg: shared PPU mode encoding, STAT enable layout and line timing constants
package ppu_pkg;
    typedef enum logic [1:0] {
        HBLANK   = 2'd0,
        VBLANK   = 2'd1,
        OAM_SCAN = 2'd2,
        XFER     = 2'd3
    } ppu_mode_t;
    typedef struct packed {
        logic lyc;
        logic oam;
        logic vblank;
        logic hblank;
    } stat_en_t;
    localparam logic [8:0] DOTS_PER_LINE = 9'd456;
    localparam logic [8:0] SCAN_DOTS     = 9'd80;
    localparam logic [8:0] XFER_TIMEOUT  = 9'd376;
    localparam logic [7:0] VISIBLE_LINES = 8'd144;
    localparam logic [7:0] TOTAL_LINES   = 8'd154;
    localparam logic [8:0] LAST_DOT      = DOTS_PER_LINE - 9'd1;
    localparam logic [7:0] LAST_LINE     = TOTAL_LINES - 8'd1;
endpackage

// File: rtl/ppu_dot_timer.sv
// ppu_dot_timer: dot and line counters, held at the frame origin while the LCD is off
module ppu_dot_timer
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_en,
    output logic [8:0] dot,
    output logic [7:0] ly,
    output logic       end_of_line
);
    assign end_of_line = dot == LAST_DOT;
    always_ff @(posedge clk) begin
        if (!rst || !lcd_en) begin
            dot <= '0;
            ly  <= '0;
        end else begin
            dot <= end_of_line ? '0 : dot + 9'd1;
            if (end_of_line) ly <= ly == LAST_LINE ? '0 : ly + 8'd1;
        end
    end
endmodule

// File: rtl/ppu_line_sequencer.sv
// ppu_line_sequencer: PPU mode, sprite chain sequencing, OAM arbitration and VBLANK/STAT interrupts
module ppu_line_sequencer
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_en,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_en,
    input  logic       px_line_done,
    input  logic       px_sprite_req,
    input  logic       cpu_oam_req,
    output logic [7:0] ly,
    output logic [8:0] dot,
    output logic [1:0] mode,
    output logic       chain_rst_n,
    output logic       chain_load,
    output logic       chain_query,
    output logic       oam_ppu_sel,
    output logic       cpu_oam_gnt,
    output logic       lyc_match,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       xfer_overrun
);
    logic      end_of_line, xfer_done, in_xfer, at_timeout, stat_line, stat_line_q;
    ppu_mode_t cur_mode;
    stat_en_t  en;

    ppu_dot_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .lcd_en      (lcd_en),
        .dot         (dot),
        .ly          (ly),
        .end_of_line (end_of_line)
    );

    assign en = stat_en_t'(stat_en);

    always_comb begin
        cur_mode   = !lcd_en ? HBLANK :
                     ly >= VISIBLE_LINES ? VBLANK :
                     dot < SCAN_DOTS ? OAM_SCAN :
                     !xfer_done ? XFER : HBLANK;
        in_xfer    = cur_mode == XFER;
        at_timeout = dot == XFER_TIMEOUT - 9'd1;
        stat_line  = (en.hblank & (cur_mode == HBLANK) & lcd_en) |
                     (en.vblank & (cur_mode == VBLANK)) |
                     (en.oam & (cur_mode == OAM_SCAN)) |
                     (en.lyc & lyc_match);
    end

    // chain is reset on the last dot so it starts every line empty at OAM address 0
    assign mode        = cur_mode;
    assign chain_rst_n = lcd_en & !end_of_line;
    assign chain_load  = cur_mode == OAM_SCAN;
    assign chain_query = in_xfer & px_sprite_req;
    assign oam_ppu_sel = (cur_mode == OAM_SCAN) | in_xfer;
    assign cpu_oam_gnt = cpu_oam_req & !oam_ppu_sel;

    always_ff @(posedge clk) begin
        if (!rst) xfer_overrun <= 1'b0;
        else if (in_xfer & at_timeout & !px_line_done) xfer_overrun <= 1'b1;
        if (!rst || !lcd_en) begin
            xfer_done   <= 1'b0;
            lyc_match   <= 1'b0;
            stat_line_q <= 1'b0;
            vblank_irq  <= 1'b0;
            stat_irq    <= 1'b0;
        end else begin
            xfer_done   <= end_of_line ? 1'b0 : xfer_done | (in_xfer & (px_line_done | at_timeout));
            lyc_match   <= ly == lyc;
            stat_line_q <= stat_line;
            vblank_irq  <= (ly == VISIBLE_LINES) & (dot == '0);
            stat_irq    <= stat_line & !stat_line_q;
        end
    end
endmodule

// File: tb/tb_ppu_line_sequencer.sv
// tb_ppu_line_sequencer: randomized stimulus checked every cycle against a frame-position model
module tb_ppu_line_sequencer;
    logic       clk = 0, rst = 0, lcd_en = 0, px_line_done = 0, px_sprite_req = 0, cpu_oam_req = 0;
    logic [7:0] lyc = 0;
    logic [3:0] stat_en = 0;
    logic [7:0] ly;
    logic [8:0] dot;
    logic [1:0] mode;
    logic       chain_rst_n, chain_load, chain_query, oam_ppu_sel, cpu_oam_gnt;
    logic       lyc_match, vblank_irq, stat_irq, xfer_overrun;

    ppu_line_sequencer dut (
        .clk (clk), .rst (rst), .lcd_en (lcd_en), .lyc (lyc), .stat_en (stat_en),
        .px_line_done (px_line_done), .px_sprite_req (px_sprite_req), .cpu_oam_req (cpu_oam_req),
        .ly (ly), .dot (dot), .mode (mode), .chain_rst_n (chain_rst_n), .chain_load (chain_load),
        .chain_query (chain_query), .oam_ppu_sel (oam_ppu_sel), .cpu_oam_gnt (cpu_oam_gnt),
        .lyc_match (lyc_match), .vblank_irq (vblank_irq), .stat_irq (stat_irq),
        .xfer_overrun (xfer_overrun)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int pos = 0, xend = 999, frame = 0, done_dot = 999, cnt10 = 0, cnt11 = 0;
    bit ovr = 0, m_lyc = 0, m_sl = 0, m_vb = 0, m_si = 0, armed = 0, force_req = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // pos counts enabled dots since the frame origin; everything else derives from it
    always @(negedge clk) begin : cmp
        int d, l, m;
        bit sl;
        d  = pos % 456;
        l  = (pos / 456) % 154;
        m  = !lcd_en ? 0 : l >= 144 ? 1 : d < 80 ? 2 : d < xend ? 3 : 0;
        sl = (stat_en[0] && m == 0 && lcd_en) || (stat_en[1] && m == 1) ||
             (stat_en[2] && m == 2) || (stat_en[3] && m_lyc);
        if (armed) begin
            chk("dot", dot, d);
            chk("ly", ly, l);
            chk("mode", mode, m);
            chk("chain_rst_n", chain_rst_n, lcd_en && d != 455);
            chk("chain_load", chain_load, m == 2);
            chk("chain_query", chain_query, m == 3 && px_sprite_req);
            chk("oam_ppu_sel", oam_ppu_sel, m >= 2);
            chk("cpu_oam_gnt", cpu_oam_gnt, cpu_oam_req && m < 2);
            chk("lyc_match", lyc_match, m_lyc);
            chk("vblank_irq", vblank_irq, m_vb);
            chk("stat_irq", stat_irq, m_si);
            chk("xfer_overrun", xfer_overrun, ovr);
            if (frame == 0 && lcd_en && rst) begin
                if (l == 0 && d == 79) chk("l0_load_d79", chain_load, 1);
                if (l == 0 && d == 80) begin
                    chk("l0_xfer_d80", mode, 3);
                    chk("l0_load_d80", chain_load, 0);
                end
                if (l == 0 && d == 454) chk("l0_chain_rst_d454", chain_rst_n, 1);
                if (l == 0 && d == 455) chk("l0_chain_rst_d455", chain_rst_n, 0);
                if (l == 3 && d <= 200) chk("l3_gnt_busy", cpu_oam_gnt, 0);
                if (l == 3 && d >= 201) chk("l3_gnt_hblank", cpu_oam_gnt, 1);
                if (l == 5 && d == 252) chk("l5_xfer_d252", mode, 3);
                if (l == 5 && d == 253) begin
                    chk("l5_hblank_d253", mode, 0);
                    chk("l5_query_off", chain_query, 0);
                end
                if (l == 5 && d == 300) chk("l5_no_overrun", xfer_overrun, 0);
                if (l == 7 && d == 375) chk("l7_xfer_d375", mode, 3);
                if (l == 7 && d == 376) chk("l7_hblank_d376", mode, 0);
                if (l == 7 && d == 377) chk("l7_overrun", xfer_overrun, 1);
                if (l == 10 && d == 2) chk("l10_lyc_pulse", stat_irq, 1);
                if (l == 10) cnt10 += int'(stat_irq);
                if (l == 11) cnt11 += int'(stat_irq);
                if (l == 12 && d == 0) begin
                    chk("l10_pulse_count", cnt10, 1);
                    chk("l11_pulse_count", cnt11, 1);
                end
                if (l == 144 && d == 0) begin
                    chk("l144_vblank_mode", mode, 1);
                    chk("l144_irq_d0", vblank_irq, 0);
                end
                if (l == 144 && d == 1) chk("l144_irq_d1", vblank_irq, 1);
                if (l == 144 && d == 2) chk("l144_irq_d2", vblank_irq, 0);
                if (l == 150 && d == 40) chk("l150_no_load", chain_load, 0);
            end
            if (frame == 1 && pos == 0 && lcd_en && rst) begin
                chk("wrap_ly", ly, 0);
                chk("wrap_mode", mode, 2);
            end
        end
        if (!rst) begin
            pos = 0; xend = 999; ovr = 0; armed = 1;
            m_lyc = 0; m_sl = 0; m_vb = 0; m_si = 0;
        end else if (!lcd_en) begin
            pos = 0; xend = 999;
            m_lyc = 0; m_sl = 0; m_vb = 0; m_si = 0;
        end else begin
            if (m == 3 && (px_line_done || d == 375)) begin
                xend = d + 1;
                if (!px_line_done) ovr = 1;
            end
            m_si  = sl && !m_sl;
            m_sl  = sl;
            m_lyc = (l == int'(lyc));
            m_vb  = (l == 144 && d == 0);
            pos++;
            if (pos == 456 * 154) begin
                pos = 0;
                frame++;
            end
            if (pos % 456 == 0) xend = 999;
        end
    end

    task automatic drive();
        int d = pos % 456;
        int l = (pos / 456) % 154;
        if (d == 0) begin
            done_dot = (frame == 0 && l == 0) ? 150 : (frame == 0 && l == 3) ? 200 :
                       (frame == 0 && l == 5) ? 252 : (frame == 0 && l == 7) ? 999 :
                       int'($urandom_range(80, (frame == 0 && l < 8) ? 370 : 420));
            lyc = (frame == 0) ? 8'd10 : 8'(l + int'($urandom_range(0, 2)));
            stat_en = (frame == 0 && l < 13) ? 4'b1001 : 4'($urandom);
        end
        px_line_done  = (d == done_dot) ? 1'b1 :
                        (d < 80 || l >= 144 || d > done_dot) ? 1'($urandom % 4 == 0) : 1'b0;
        px_sprite_req = (frame == 0 && l == 5) ? 1'b1 : 1'($urandom);
        cpu_oam_req   = (force_req || (frame == 0 && l == 3)) ? 1'b1 : 1'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    initial begin
        rst = 0;
        lcd_en = 0;
        drive();
        repeat (4) step();
        @(negedge clk);
        chk("rst_dot", dot, 0);
        chk("rst_ly", ly, 0);
        chk("rst_mode", mode, 0);
        chk("rst_chain_rst_n", chain_rst_n, 0);
        chk("rst_overrun", xfer_overrun, 0);
        step();
        rst = 1;
        repeat (3) step();
        lcd_en = 1;
        drive();
        repeat (70224 + 2 * 456 + 100) step();
        force_req = 1;
        lcd_en = 0;
        drive();
        @(negedge clk);
        chk("drop_gnt", cpu_oam_gnt, 1);
        chk("drop_mode", mode, 0);
        step();
        @(negedge clk);
        chk("drop_dot", dot, 0);
        chk("drop_chain_rst_n", chain_rst_n, 0);
        force_req = 0;
        repeat (2) step();
        lcd_en = 1;
        drive();
        @(negedge clk);
        chk("en_dot", dot, 0);
        chk("en_mode", mode, 2);
        repeat (300) step();
        repeat (20) begin
            lcd_en = 1'($urandom % 6 != 0);
            drive();
            repeat ($urandom_range(1, 300)) step();
        end
        lcd_en = 1;
        rst = 0;
        drive();
        step();
        @(negedge clk);
        chk("final_rst_overrun", xfer_overrun, 0);
        rst = 1;
        repeat (5) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
